// File: rtl/dpram_fifo_ctrl_pkg.sv
// Shared defaults and read-side state encoding for the dual-port-RAM FIFO controller.
package dpram_fifo_ctrl_pkg;

  localparam int WIDTH_DEF  = 8;
  localparam int DEPTH_DEF  = 16;
  localparam int ADDR_W_DEF = 4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2
  } rd_state_t;

endpackage

// File: rtl/dpram_fifo_ctrl_fifo_ptr.sv
// Wrapping RAM address pointer; DEPTH is a power of two so natural overflow wraps to 0.
module fifo_ptr
  import dpram_fifo_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  output logic [ADDR_W-1:0] ptr
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      ptr <= '0;
    else if (inc) ptr <= ptr + ADDR_W'(1);
  end

endmodule

// File: rtl/dpram_fifo_ctrl.sv
// FIFO controller around an external dual-port RAM: port A writes, port B registered reads
// feed a one-word output register.
//
// state | meaning
// EMPTY | output register holds nothing
// FETCH | RAM read issued last cycle, data lands in rd_data at this edge
// VALID | rd_data holds the oldest word
module dpram_fifo_ctrl
  import dpram_fifo_ctrl_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [WIDTH-1:0]  wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [WIDTH-1:0]  rd_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic [WIDTH-1:0]  ram_din_a,
  output logic [ADDR_W-1:0] ram_addr_a,
  output logic              ram_we_a,
  output logic              ram_re_a,
  output logic [ADDR_W-1:0] ram_addr_b,
  output logic              ram_re_b,
  output logic              ram_we_b,
  output logic [WIDTH-1:0]  ram_din_b,
  input  logic [WIDTH-1:0]  ram_dout_b
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   ram_cnt;
  rd_state_t         state;
  logic              push;
  logic              fetch;

  assign full     = (ram_cnt == FULL_CNT);
  assign wr_ready = !full;
  assign push     = wr_valid && !full;
  // A fetch only needs a word in RAM; a push only needs a free slot, so the two never collide.
  assign fetch    = (ram_cnt != '0) &&
                    ((state == EMPTY) || ((state == VALID) && rd_ready));

  assign ram_we_a   = push;
  assign ram_addr_a = wr_ptr;
  assign ram_din_a  = wr_data;
  assign ram_re_a   = 1'b0;
  assign ram_re_b   = fetch;
  assign ram_addr_b = rd_ptr;
  assign ram_we_b   = 1'b0;
  assign ram_din_b  = '0;

  assign rd_valid = (state == VALID);
  assign count    = ram_cnt + {{ADDR_W{1'b0}}, (state != EMPTY)};
  assign empty    = (count == '0);

  fifo_ptr #(.ADDR_W(ADDR_W)) u_wr_ptr (.clk(clk), .rst(rst), .inc(push),  .ptr(wr_ptr));
  fifo_ptr #(.ADDR_W(ADDR_W)) u_rd_ptr (.clk(clk), .rst(rst), .inc(fetch), .ptr(rd_ptr));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= EMPTY;
      ram_cnt <= '0;
      rd_data <= '0;
    end else begin
      case ({push, fetch})
        2'b10:   ram_cnt <= ram_cnt + (ADDR_W+1)'(1);
        2'b01:   ram_cnt <= ram_cnt - (ADDR_W+1)'(1);
        default: ram_cnt <= ram_cnt;
      endcase
      case (state)
        EMPTY: if (fetch) state <= FETCH;
        FETCH: begin
          rd_data <= ram_dout_b;
          state   <= VALID;
        end
        VALID: if (rd_ready) state <= fetch ? FETCH : EMPTY;
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Scoreboard bench: a queue of accepted words is the reference; a negedge monitor checks
// every pop, occupancy, and RAM address sequencing against it.
module tb_dpram_fifo_ctrl;

  localparam int WIDTH  = 8;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wr_valid = 1'b0;
  logic              wr_ready;
  logic [WIDTH-1:0]  wr_data = '0;
  logic              rd_valid;
  logic              rd_ready = 1'b0;
  logic [WIDTH-1:0]  rd_data;
  logic              full, empty;
  logic [ADDR_W:0]   count;
  logic [WIDTH-1:0]  ram_din_a, ram_din_b, ram_dout_b;
  logic [ADDR_W-1:0] ram_addr_a, ram_addr_b;
  logic              ram_we_a, ram_re_a, ram_re_b, ram_we_b;

  dpram_fifo_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .full(full), .empty(empty), .count(count),
    .ram_din_a(ram_din_a), .ram_addr_a(ram_addr_a), .ram_we_a(ram_we_a), .ram_re_a(ram_re_a),
    .ram_addr_b(ram_addr_b), .ram_re_b(ram_re_b), .ram_we_b(ram_we_b), .ram_din_b(ram_din_b),
    .ram_dout_b(ram_dout_b)
  );

  always #5 clk = ~clk;

  // Behavioural dual-port RAM with registered port-B output, reset from the same rst.
  logic [WIDTH-1:0] mem [DEPTH];
  always @(posedge clk or posedge rst) begin
    if (rst) ram_dout_b <= '0;
    else begin
      if (ram_we_a) mem[ram_addr_a] <= ram_din_a;
      if (ram_re_b) ram_dout_b <= mem[ram_addr_b];
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: words in the block, in order, plus write/read counters since reset.
  logic [WIDTH-1:0] ref_q[$];
  int wr_n = 0;
  int rd_n = 0;
  logic             hold_pending = 1'b0;
  logic [WIDTH-1:0] hold_data = '0;

  always @(negedge clk) begin
    if (rst) begin
      ref_q.delete();
      wr_n = 0;
      rd_n = 0;
      hold_pending = 1'b0;
    end else begin
      chk("count", 32'(count), 32'(ref_q.size()));
      chk("empty", 32'(empty), 32'(ref_q.size() == 0));
      chk("wr_ready_vs_full", 32'(wr_ready), 32'(!full));
      if (full) chk("full_occupancy", 32'(ref_q.size() >= DEPTH), 32'd1);
      if (hold_pending) begin
        chk("hold_valid", 32'(rd_valid), 32'd1);
        chk("hold_data", 32'(rd_data), 32'(hold_data));
      end
      if (ram_we_a) begin
        chk("wr_addr_seq", 32'(ram_addr_a), 32'(wr_n % DEPTH));
        wr_n++;
      end
      if (ram_re_b) begin
        chk("rd_addr_seq", 32'(ram_addr_b), 32'(rd_n % DEPTH));
        rd_n++;
        if (ram_we_a) chk("addr_collision", 32'(ram_addr_a != ram_addr_b), 32'd1);
      end
      if (rd_valid && rd_ready) begin
        if (ref_q.size() == 0) chk("pop_underflow", 32'd1, 32'd0);
        else chk("rd_data", 32'(rd_data), 32'(ref_q.pop_front()));
      end
      if (wr_valid && wr_ready) ref_q.push_back(wr_data);
      hold_pending = rd_valid && !rd_ready;
      hold_data    = rd_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
    chk({tag, "_empty"},    32'(empty),    32'd1);
    chk({tag, "_full"},     32'(full),     32'd0);
    chk({tag, "_count"},    32'(count),    32'd0);
    chk({tag, "_we_a"},     32'(ram_we_a), 32'd0);
    chk({tag, "_re_b"},     32'(ram_re_b), 32'd0);
    chk({tag, "_rd_data"},  32'(rd_data),  32'd0);
  endtask

  task automatic drain(input string tag);
    int k;
    wr_valid = 1'b0;
    rd_ready = 1'b1;
    k = 0;
    while (!empty && k < 200) begin
      tick();
      k++;
    end
    rd_ready = 1'b0;
    chk({tag, "_drain_timeout"}, 32'(k < 200), 32'd1);
    chk({tag, "_drained_empty"}, 32'(empty), 32'd1);
    tick();
    chk({tag, "_idle_rd_valid"}, 32'(rd_valid), 32'd0);
  endtask

  initial begin
    int pushed, k;

    #1;
    check_reset_outputs("rst0");
    chk("rst0_ram_re_a", 32'(ram_re_a), 32'd0);
    chk("rst0_ram_we_b", 32'(ram_we_b), 32'd0);
    chk("rst0_ram_din_b", 32'(ram_din_b), 32'd0);
    do_reset();

    // Single push latency
    wr_valid = 1'b1; wr_data = 8'hA1;
    #1;
    chk("a1_we_a", 32'(ram_we_a), 32'd1);
    chk("a1_addr_a", 32'(ram_addr_a), 32'd0);
    chk("a1_din_a", 32'(ram_din_a), 32'hA1);
    tick();
    wr_valid = 1'b0;
    tick();
    chk("a1_not_yet_valid", 32'(rd_valid), 32'd0);
    tick();
    chk("a1_valid", 32'(rd_valid), 32'd1);
    chk("a1_data", 32'(rd_data), 32'hA1);
    chk("a1_count", 32'(count), 32'd1);
    drain("a1");

    // Fill to full with no reads, then drain
    do_reset();
    for (int i = 0; i < 16; i++) begin
      wr_valid = 1'b1; wr_data = 8'(i);
      tick();
    end
    chk("fill16_full", 32'(full), 32'd0);
    wr_data = 8'h10;
    tick();
    chk("fill17_full", 32'(full), 32'd1);
    chk("fill17_count", 32'(count), 32'd17);
    chk("fill17_wr_ready", 32'(wr_ready), 32'd0);
    wr_data = 8'h55;
    #1;
    chk("full_no_write", 32'(ram_we_a), 32'd0);
    tick();
    chk("full_push_ignored", 32'(count), 32'd17);
    drain("fill");

    // Interleaved random traffic, 40 words of i*3 across several pointer wraps
    do_reset();
    pushed = 0;
    k = 0;
    while ((pushed < 40 || !empty) && k < 2000) begin
      wr_valid = (pushed < 40) && ($urandom_range(0, 3) != 0);
      wr_data  = 8'(pushed * 3);
      rd_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (wr_valid && wr_ready) pushed++;
      tick();
      k++;
    end
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    chk("wrap_timeout", 32'(k < 2000), 32'd1);
    chk("wrap_writes", 32'(wr_n), 32'd40);
    chk("wrap_reads", 32'(rd_n), 32'd40);

    // Simultaneous push and fetch with five words in RAM
    do_reset();
    for (int i = 0; i < 6; i++) begin
      wr_valid = 1'b1; wr_data = 8'(8'h40 + i);
      tick();
    end
    wr_valid = 1'b0;
    tick(); tick();
    chk("sim_pre_valid", 32'(rd_valid), 32'd1);
    chk("sim_pre_count", 32'(count), 32'd6);
    wr_valid = 1'b1; wr_data = 8'h77; rd_ready = 1'b1;
    #1;
    chk("sim_both", 32'(ram_we_a && ram_re_b), 32'd1);
    chk("sim_addr_differ", 32'(ram_addr_a != ram_addr_b), 32'd1);
    tick();
    wr_valid = 1'b0; rd_ready = 1'b0;
    chk("sim_fetch_state", 32'(rd_valid), 32'd0);
    chk("sim_count_after", 32'(count), 32'd6);
    drain("sim");

    // Asynchronous reset during a fetch
    do_reset();
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1; wr_data = 8'(8'hC0 + i);
      tick();
    end
    wr_valid = 1'b0;
    tick(); tick();
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    chk("arst_pre_fetch", 32'(rd_valid), 32'd0);
    chk("arst_pre_count", 32'(count), 32'd3);
    rst = 1'b1;
    #1;
    check_reset_outputs("arst");
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("arst_no_valid", 32'(rd_valid), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
